// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the RAM arbiter (grant FSM states, port ids).
package ram_arb_pkg;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_LDR = 1;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port machine RAM between the CPU (port 0) and
// the loader/DMA/debug master (port 1). Registered round-robin grant with a
// burst limit; 1-cycle read data is steered back to whichever port issued it.
// Optional build macro RAM_ARBITER_STATS_EN adds saturating access/stall counters.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
`ifdef RAM_ARBITER_STATS_EN
   output logic [15:0]       acc_cnt0,
   output logic [15:0]       acc_cnt1,
   output logic [15:0]       stall_cnt,
`endif
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int              CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
   // burst_cnt value at which the current access is the last one allowed
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t       state, state_nxt;
   logic             last_owner;
   logic [CNT_W-1:0] burst_cnt, burst_inc;
   logic             acc0, acc1, at_limit;

   assign gnt0      = (state == OWN0);
   assign gnt1      = (state == OWN1);
   assign acc0      = gnt0 & req0;
   assign acc1      = gnt1 & req1;
   assign at_limit  = (burst_cnt >= BURST_LAST);
   assign burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);

   // Both ports see the raw RAM data; rvalid tells the issuer it is theirs.
   assign rdata0 = ram_rdata;
   assign rdata1 = ram_rdata;

   // Next owner: round-robin on a tie from IDLE, hand over on release or burst limit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0 && req1)
               state_nxt = (last_owner == 1'(PORT_LDR)) ? OWN0 : OWN1;
            else if (req0)
               state_nxt = OWN0;
            else if (req1)
               state_nxt = OWN1;
         end
         OWN0: begin
            if (!req0)
               state_nxt = req1 ? OWN1 : IDLE;
            else if (req1 && at_limit)
               state_nxt = OWN1;
         end
         OWN1: begin
            if (!req1)
               state_nxt = req0 ? OWN0 : IDLE;
            else if (req0 && at_limit)
               state_nxt = OWN0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, fairness bookkeeping and the 1-cycle read-valid pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= 1'(PORT_LDR);
         burst_cnt  <= '0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
      end else begin
         state   <= state_nxt;
         rvalid0 <= acc0 & ~we0;
         rvalid1 <= acc1 & ~we1;
         if (state_nxt != state) begin
            burst_cnt <= '0;
            if (state != IDLE)
               last_owner <= (state == OWN1) ? 1'(PORT_LDR) : 1'(PORT_CPU);
         end else if (acc0 || acc1) begin
            burst_cnt <= burst_inc;
         end
      end
   end

   // RAM port mux from the owner; write is suppressed in any reset cycle.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      if (state == OWN0) begin
         ram_addr  = addr0;
         ram_wdata = wdata0;
         ram_we    = acc0 & we0;
      end else if (state == OWN1) begin
         ram_addr  = addr1;
         ram_wdata = wdata1;
         ram_we    = acc1 & we1;
      end
      if (reset)
         ram_we = 1'b0;
   end

`ifdef RAM_ARBITER_STATS_EN
   // Saturating per-port access counts and a once-per-cycle stall count.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_cnt0  <= '0;
         acc_cnt1  <= '0;
         stall_cnt <= '0;
      end else begin
         if (acc0 && acc_cnt0 != 16'hFFFF)
            acc_cnt0 <= acc_cnt0 + 16'd1;
         if (acc1 && acc_cnt1 != 16'hFFFF)
            acc_cnt1 <= acc_cnt1 + 16'd1;
         if (((req0 && !gnt0) || (req1 && !gnt1)) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scenario tasks drive both masters against a behavioural
// 1-cycle RAM; read results are predicted from a reference memory image and
// queued, then matched as rvalid0/rvalid1 appear.
// Build with RAM_ARBITER_STATS_EN defined to also cover the statistics counters.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic       gnt0, gnt1, rvalid0, rvalid1, ram_we;
   logic [7:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
`ifdef RAM_ARBITER_STATS_EN
   logic [15:0] acc_cnt0, acc_cnt1, stall_cnt;
`endif

   // RAM model (written only by the DUT or the backdoor) and the bench's reference image
   logic [7:0] mem [256];
   bit   [255:0] mem_v;
   logic [7:0] ref_mem [256];
   logic       bd_we = 1'b0;
   logic [7:0] bd_a = '0, bd_d = '0;

   typedef struct {int port; logic [7:0] data;} rd_exp_t;
   rd_exp_t sb[$];
   int vecs = 0;
   int errs = 0;

   ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
`ifdef RAM_ARBITER_STATS_EN
      .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1), .stall_cnt(stall_cnt),
`endif
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Single-port RAM, read-first, 1-cycle latency; unwritten cells read a fixed pattern
   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_a]   <= bd_d;
         mem_v[bd_a] <= 1'b1;
      end else if (ram_we === 1'b1) begin
         mem[ram_addr]   <= ram_wdata;
         mem_v[ram_addr] <= 1'b1;
      end
      ram_rdata <= mem_v[ram_addr] ? mem[ram_addr] : (ram_addr ^ 8'hC3);
   end

   // Scoreboard drain: every read-valid must match the oldest predicted read
   always @(negedge clk) begin
      rd_exp_t    e;
      int         p;
      logic [7:0] d;
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
         vecs++;
         p = (rvalid1 === 1'b1) ? 1 : 0;
         d = p ? rdata1 : rdata0;
         if (sb.size() == 0) begin
            errs++;
            $display("FAIL rd_unexpected rvalid0=%b rvalid1=%b data=%h", rvalid0, rvalid1, d);
         end else begin
            e = sb.pop_front();
            if ((rvalid0 === 1'b1 && rvalid1 === 1'b1) || p != e.port || d !== e.data) begin
               errs++;
               $display("FAIL rd_data got port=%0d data=%h (rv0=%b rv1=%b) exp port=%0d data=%h",
                        p, d, rvalid0, rvalid1, e.port, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      bd_a = a; bd_d = d; bd_we = 1'b1;
      nxt();
      bd_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic test_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h44; wdata0 = 8'h77;
      mid();
      vecs++; if (gnt0 !== 1'b0) begin errs++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
      vecs++; if (gnt1 !== 1'b0) begin errs++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
      vecs++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errs++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
      vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      vecs++; if (ram_addr !== 8'h00) begin errs++; $display("FAIL reset_ram_addr got=%h exp=00", ram_addr); end
      nxt();
      reset = 1'b0; req0 = 1'b0; we0 = 1'b0;
   endtask

   task automatic test_cpu_alone();
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
      mid();
      vecs++; if (gnt0 !== 1'b0) begin errs++; $display("FAIL cpu_gnt_latency got=%b exp=0", gnt0); end
      vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL cpu_idle_we got=%b exp=0", ram_we); end
      nxt(); mid();
      vecs++; if (gnt0 !== 1'b1) begin errs++; $display("FAIL cpu_gnt got=%b exp=1", gnt0); end
      vecs++; if (ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 8'hA5) begin
         errs++; $display("FAIL cpu_write got we=%b a=%h d=%h exp we=1 a=10 d=a5", ram_we, ram_addr, ram_wdata); end
      ref_mem[8'h10] = 8'hA5;
      nxt(); we0 = 1'b0; mid();
      vecs++; if (gnt0 !== 1'b1 || ram_we !== 1'b0) begin errs++; $display("FAIL cpu_read_issue got gnt0=%b we=%b exp 1 0", gnt0, ram_we); end
      sb.push_back('{0, ref_mem[8'h10]});
      nxt(); req0 = 1'b0; mid();
      vecs++; if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin errs++; $display("FAIL cpu_rdata got rv=%b d=%h exp rv=1 d=a5", rvalid0, rdata0); end
      nxt(); mid();
      vecs++; if (gnt0 !== 1'b0) begin errs++; $display("FAIL cpu_release got gnt0=%b exp=0", gnt0); end
      nxt();
   endtask

   task automatic test_tie();
      reset = 1'b1; nxt(); reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
      mid();
      vecs++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errs++; $display("FAIL tie_idle got gnt=%b%b exp=00", gnt0, gnt1); end
      nxt(); mid();
      vecs++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL tie_cpu_first got gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1); end
      vecs++; if (ram_addr !== 8'h01) begin errs++; $display("FAIL tie_addr0 got=%h exp=01", ram_addr); end
      sb.push_back('{0, ref_mem[8'h01]});
      nxt(); req0 = 1'b0; mid();
      nxt(); mid();
      vecs++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errs++; $display("FAIL tie_handover got gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1); end
      vecs++; if (ram_addr !== 8'h02) begin errs++; $display("FAIL tie_addr1 got=%h exp=02", ram_addr); end
      sb.push_back('{1, ref_mem[8'h02]});
      nxt(); req1 = 1'b0; mid();
      nxt(); mid();
      vecs++; if (gnt1 !== 1'b0) begin errs++; $display("FAIL tie_release got gnt1=%b exp=0", gnt1); end
      nxt();
   endtask

   task automatic test_burst();
      // expected owner per cycle: N=none, L=loader, C=cpu
      string own;
      byte   o;
      int    ld_n, cpu_n;
      own = "NLLLLCCCCLLLLCCCLLLN";
      ld_n = 0; cpu_n = 0;
      for (int c = 0; c < 20; c++) begin
         req1 = (ld_n < 10);  we1 = 1'b0; addr1 = 8'h40 + 8'(ld_n);
         req0 = (c >= 1) && (cpu_n < 6); we0 = 1'b0; addr0 = 8'h80 + 8'(cpu_n);
         mid();
         o = own[c];
         vecs++;
         if (gnt0 !== (o == "C") || gnt1 !== (o == "L")) begin
            errs++; $display("FAIL burst_owner cycle=%0d got gnt0=%b gnt1=%b exp owner=%c", c, gnt0, gnt1, o);
         end
         if (gnt1 === 1'b1 && req1) begin sb.push_back('{1, ref_mem[addr1]}); ld_n++; end
         if (gnt0 === 1'b1 && req0) begin sb.push_back('{0, ref_mem[addr0]}); cpu_n++; end
         nxt();
      end
      vecs++; if (ld_n != 10 || cpu_n != 6) begin errs++; $display("FAIL burst_totals got ld=%0d cpu=%0d exp ld=10 cpu=6", ld_n, cpu_n); end
   endtask

   task automatic test_handoff();
      poke(8'h20, 8'h3C);
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h1D;
      mid();
      vecs++; if (gnt1 !== 1'b0) begin errs++; $display("FAIL hand_idle got gnt1=%b exp=0", gnt1); end
      nxt();
      for (int k = 0; k < 4; k++) begin
         addr1 = 8'h1D + 8'(k);
         req0 = 1'b1; we0 = 1'b1; addr0 = 8'h21; wdata0 = 8'h99;
         mid();
         vecs++; if (gnt1 !== 1'b1 || ram_addr !== addr1) begin
            errs++; $display("FAIL hand_ldr_access k=%0d got gnt1=%b a=%h exp gnt1=1 a=%h", k, gnt1, ram_addr, addr1); end
         sb.push_back('{1, ref_mem[addr1]});
         nxt();
      end
      req1 = 1'b0; mid();
      vecs++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL hand_switch got gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1); end
      vecs++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h3C) begin errs++; $display("FAIL hand_rdata1 got rv=%b d=%h exp rv=1 d=3c", rvalid1, rdata1); end
      vecs++; if (rvalid0 !== 1'b0) begin errs++; $display("FAIL hand_rvalid0 got=%b exp=0", rvalid0); end
      vecs++; if (ram_we !== 1'b1 || ram_addr !== 8'h21 || ram_wdata !== 8'h99) begin
         errs++; $display("FAIL hand_cpu_write got we=%b a=%h d=%h exp we=1 a=21 d=99", ram_we, ram_addr, ram_wdata); end
      ref_mem[8'h21] = 8'h99;
      nxt(); req0 = 1'b0; mid();
      vecs++; if (rvalid0 !== 1'b0) begin errs++; $display("FAIL hand_write_no_rvalid got=%b exp=0", rvalid0); end
      vecs++; if (mem[8'h21] !== ref_mem[8'h21]) begin errs++; $display("FAIL hand_mem21 got=%h exp=%h", mem[8'h21], ref_mem[8'h21]); end
      nxt(); nxt();
   endtask

   task automatic test_reset_mid();
      poke(8'h30, 8'h11);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h55;
      mid();
      nxt();
      reset = 1'b1; mid();
      vecs++; if (gnt0 !== 1'b1 || ram_we !== 1'b0) begin errs++; $display("FAIL rstmid_we_gate got gnt0=%b we=%b exp 1 0", gnt0, ram_we); end
      nxt();
      reset = 1'b0; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
      mid();
      vecs++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errs++; $display("FAIL rstmid_idle got gnt=%b%b exp=00", gnt0, gnt1); end
      vecs++; if (mem[8'h30] !== 8'h11) begin errs++; $display("FAIL rstmid_mem30 got=%h exp=11", mem[8'h30]); end
      nxt(); mid();
      vecs++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL rstmid_tie got gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1); end
      sb.push_back('{0, ref_mem[8'h30]});
      nxt(); req0 = 1'b0; mid();
      nxt(); mid();
      vecs++; if (gnt1 !== 1'b1) begin errs++; $display("FAIL rstmid_ldr got gnt1=%b exp=1", gnt1); end
      sb.push_back('{1, ref_mem[8'h31]});
      nxt(); req1 = 1'b0; mid();
      nxt(); nxt();
   endtask

`ifdef RAM_ARBITER_STATS_EN
   task automatic test_stats();
      reset = 1'b1; nxt(); reset = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h60; wdata0 = 8'hE0;
      mid();
      vecs++; if (acc_cnt0 !== 16'd0 || acc_cnt1 !== 16'd0 || stall_cnt !== 16'd0) begin
         errs++; $display("FAIL stats_reset got %0d %0d %0d exp 0 0 0", acc_cnt0, acc_cnt1, stall_cnt); end
      nxt();
      for (int k = 0; k < 3; k++) begin
         addr0 = 8'h60 + 8'(k); wdata0 = 8'hE0 + 8'(k); ref_mem[addr0] = wdata0; nxt();
      end
      req0 = 1'b0; nxt();
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h70; wdata1 = 8'hF0; nxt();
      for (int k = 0; k < 5; k++) begin
         addr1 = 8'h70 + 8'(k); wdata1 = 8'hF0 + 8'(k); ref_mem[addr1] = wdata1; nxt();
      end
      req1 = 1'b0; we1 = 1'b0; nxt();
      mid();
      vecs++; if (acc_cnt0 !== 16'd3) begin errs++; $display("FAIL stats_acc0 got=%0d exp=3", acc_cnt0); end
      vecs++; if (acc_cnt1 !== 16'd5) begin errs++; $display("FAIL stats_acc1 got=%0d exp=5", acc_cnt1); end
      vecs++; if (stall_cnt !== 16'd2) begin errs++; $display("FAIL stats_stall got=%0d exp=2", stall_cnt); end
      vecs++; if (mem[8'h62] !== ref_mem[8'h62] || mem[8'h74] !== ref_mem[8'h74]) begin
         errs++; $display("FAIL stats_mem got %h %h exp %h %h", mem[8'h62], mem[8'h74], ref_mem[8'h62], ref_mem[8'h74]); end
      nxt();
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hC3;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_cpu_alone();
      test_tie();
      test_burst();
      test_handoff();
      test_reset_mid();
`ifdef RAM_ARBITER_STATS_EN
      test_stats();
`endif
      repeat (2) @(negedge clk);
      vecs++;
      if (sb.size() != 0) begin errs++; $display("FAIL rd_missing got %0d reads outstanding exp 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
